reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 22 ++
 rtl/reg_bank_rdport.sv | 72 +++++++
 rtl/reg_bank.sv | 113 +++++++++++
 tb/tb_reg_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults and parameter legality checks for the reg_bank slice.
//   DefaultWidth / DefaultDepth : default data width and register count
//   width_ok() / depth_ok()     : elaboration-time range checks used by reg_bank
package reg_bank_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultDepth = 8;

    localparam int unsigned MinWidth = 8;
    localparam int unsigned MaxWidth = 128;
    localparam int unsigned MinDepth = 2;
    localparam int unsigned MaxDepth = 64;

    function automatic bit width_ok(int unsigned w);
        return (w % 8 == 0) && (w >= MinWidth) && (w <= MaxWidth);
    endfunction

    function automatic bit depth_ok(int unsigned d);
        return (d >= MinDepth) && (d <= MaxDepth);
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one registered read port of the register bank.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   rd_en_i, rd_addr_i  : read request and index
//   mem_i               : current register contents (all registers)
//   wr_*_i              : the write being applied on the same edge (for write-first)
//   rd_data_o           : registered read data, held while rd_en_i=0
//   oor_o               : combinational flag, enabled read with index >= DEPTH
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned NB = WIDTH / 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rd_en_i,
    input  logic [AW-1:0]                     rd_addr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]       mem_i,
    input  logic                              wr_en_i,
    input  logic [AW-1:0]                     wr_addr_i,
    input  logic [WIDTH-1:0]                  wr_data_i,
    input  logic [NB-1:0]                     wr_be_i,
    output logic [WIDTH-1:0]                  rd_data_o,
    output logic                              oor_o
);

    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    logic             rd_in_range;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] rd_data_d, rd_data_q;

    always_comb begin
        rd_in_range = {1'b0, rd_addr_i} < DepthW;
        oor_o       = rd_en_i && !rd_in_range;

        word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_addr_i == AW'(i)) begin
                word = mem_i[i];
            end
        end

        // Write-first: an in-range read that matches the write address sees the merged bytes.
        // A matching write address is in range whenever the read address is.
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_be_i[b]) begin
                    word[b*8 +: 8] = wr_data_i[b*8 +: 8];
                end
            end
        end

        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = rd_in_range ? word : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank, one byte-enabled write port, two registered read
// ports, per-register dirty flags and an out-of-range error pulse.
//   clk, rst                          : clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data, wr_be    : write request with byte enables
//   rd_en_a/b, rd_addr_a/b            : read requests
//   rd_data_a/b                       : registered read data (1-cycle latency)
//   clr_dirty, dirty                  : dirty-flag clear and per-register flags
//   err                               : one-cycle pulse after any out-of-range access
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [NB-1:0]    wr_be,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_dirty,
    output logic [DEPTH-1:0] dirty,
    output logic             err
);

    if (!width_ok(WIDTH) || !depth_ok(DEPTH)) begin : g_bad_param
        $error("reg_bank: illegal WIDTH/DEPTH parameters");
    end

    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;
    logic [DEPTH-1:0]            dirty_d, dirty_q;
    logic                        err_d, err_q;
    logic                        wr_hit;
    logic                        oor_a, oor_b;

    always_comb begin
        wr_hit  = wr_en && ({1'b0, wr_addr} < DepthW);
        mem_d   = mem_q;
        // Clear first so a write on the same edge leaves its own bit set.
        dirty_d = clr_dirty ? '0 : dirty_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_hit && (wr_addr == AW'(i))) begin
                dirty_d[i] = 1'b1;
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        mem_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
        err_d = (wr_en && !wr_hit) || oor_a || oor_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            dirty_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            dirty_q <= dirty_d;
            err_q   <= err_d;
        end
    end

    reg_bank_rdport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rdport_a (
        .clk_i     (clk),
        .rst_i     (rst),
        .rd_en_i   (rd_en_a),
        .rd_addr_i (rd_addr_a),
        .mem_i     (mem_q),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_be_i   (wr_be),
        .rd_data_o (rd_data_a),
        .oor_o     (oor_a)
    );

    reg_bank_rdport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rdport_b (
        .clk_i     (clk),
        .rst_i     (rst),
        .rd_en_i   (rd_en_b),
        .rd_addr_i (rd_addr_b),
        .mem_i     (mem_q),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_be_i   (wr_be),
        .rd_data_o (rd_data_b),
        .oor_o     (oor_b)
    );

    assign dirty = dirty_q;
    assign err   = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank (default 32x8 and a 32x6 instance).
module tb_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance: WIDTH=32, DEPTH=8
    logic        wr_en, rd_en_a, rd_en_b, clr_dirty, err;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data, rd_data_a, rd_data_b;
    logic [3:0]  wr_be;
    logic [7:0]  dirty;

    // Second instance: WIDTH=32, DEPTH=6 (indices 6 and 7 are out of range)
    logic        wr_en6, rd_en_a6, rd_en_b6, clr_dirty6, err6;
    logic [2:0]  wr_addr6, rd_addr_a6, rd_addr_b6;
    logic [31:0] wr_data6, rd_data_a6, rd_data_b6;
    logic [3:0]  wr_be6;
    logic [5:0]  dirty6;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank u_dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .clr_dirty (clr_dirty),
        .dirty     (dirty),
        .err       (err)
    );

    reg_bank #(
        .DEPTH (6)
    ) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en6),
        .wr_addr   (wr_addr6),
        .wr_data   (wr_data6),
        .wr_be     (wr_be6),
        .rd_en_a   (rd_en_a6),
        .rd_addr_a (rd_addr_a6),
        .rd_en_b   (rd_en_b6),
        .rd_addr_b (rd_addr_b6),
        .rd_data_a (rd_data_a6),
        .rd_data_b (rd_data_b6),
        .clr_dirty (clr_dirty6),
        .dirty     (dirty6),
        .err       (err6)
    );

    task automatic idle();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr_dirty = 1'b0;
        wr_en6 = 1'b0; rd_en_a6 = 1'b0; rd_en_b6 = 1'b0; clr_dirty6 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr_a = '0; rd_addr_b = '0;
        wr_addr6 = '0; wr_data6 = '0; wr_be6 = '0; rd_addr_a6 = '0; rd_addr_b6 = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL reset_rd_a: got %h exp 0", rd_data_a); end
        n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL reset_rd_b: got %h exp 0", rd_data_b); end
        n_checks++; if (dirty !== 8'h00) begin n_fail++; $display("FAIL reset_dirty: got %h exp 00", dirty); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err); end
        n_checks++; if (dirty6 !== 6'h00) begin n_fail++; $display("FAIL reset_dirty6: got %h exp 00", dirty6); end
        n_checks++; if (err6 !== 1'b0) begin n_fail++; $display("FAIL reset_err6: got %b exp 0", err6); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        @(negedge clk); idle();
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_a: got %h exp deadbeef", rd_data_a); end
        n_checks++; if (dirty !== 8'h08) begin n_fail++; $display("FAIL wr_dirty: got %h exp 08", dirty); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b exp 0", err); end
    endtask

    task automatic test_write_first();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h11223344; wr_be = 4'b0101;
        rd_en_b = 1'b1; rd_addr_b = 3'd3;
        @(negedge clk); idle();
        n_checks++; if (rd_data_b !== 32'hDE22BE44) begin n_fail++; $display("FAIL wfirst_rd_b: got %h exp de22be44", rd_data_b); end
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'hDE22BE44) begin n_fail++; $display("FAIL wfirst_stored: got %h exp de22be44", rd_data_a); end
    endtask

    task automatic test_dual_read();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hA5A50F0F; wr_be = 4'hF;
        @(negedge clk); idle();
        rd_en_a = 1'b1; rd_addr_a = 3'd6; rd_en_b = 1'b1; rd_addr_b = 3'd6;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'hA5A50F0F) begin n_fail++; $display("FAIL dual_same_a: got %h exp a5a50f0f", rd_data_a); end
        n_checks++; if (rd_data_b !== 32'hA5A50F0F) begin n_fail++; $display("FAIL dual_same_b: got %h exp a5a50f0f", rd_data_b); end
        rd_en_a = 1'b1; rd_addr_a = 3'd3; rd_en_b = 1'b1; rd_addr_b = 3'd6;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'hDE22BE44) begin n_fail++; $display("FAIL dual_diff_a: got %h exp de22be44", rd_data_a); end
        n_checks++; if (rd_data_b !== 32'hA5A50F0F) begin n_fail++; $display("FAIL dual_diff_b: got %h exp a5a50f0f", rd_data_b); end
        n_checks++; if (dirty !== 8'h48) begin n_fail++; $display("FAIL dual_dirty: got %h exp 48", dirty); end
    endtask

    task automatic test_hold();
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        @(negedge clk); idle();
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hCAFE0000 + k; wr_be = 4'hF;
            rd_addr_a = 3'd3;
            @(negedge clk);
            n_checks++; if (rd_data_a !== 32'hDE22BE44) begin n_fail++; $display("FAIL hold_%0d: got %h exp de22be44", k, rd_data_a); end
        end
        idle();
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'hCAFE0002) begin n_fail++; $display("FAIL hold_reread: got %h exp cafe0002", rd_data_a); end
    endtask

    task automatic test_clr_write();
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
            @(negedge clk);
        end
        idle();
        n_checks++; if (dirty !== 8'hFF) begin n_fail++; $display("FAIL be0_dirty: got %h exp ff", dirty); end
        rd_en_a = 1'b1; rd_addr_a = 3'd1; rd_en_b = 1'b1; rd_addr_b = 3'd3;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL be0_storage1: got %h exp 0", rd_data_a); end
        n_checks++; if (rd_data_b !== 32'hCAFE0002) begin n_fail++; $display("FAIL be0_storage3: got %h exp cafe0002", rd_data_b); end
        clr_dirty = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h55AA55AA; wr_be = 4'hF;
        @(negedge clk); idle();
        n_checks++; if (dirty !== 8'h20) begin n_fail++; $display("FAIL clr_write_dirty: got %h exp 20", dirty); end
        clr_dirty = 1'b1;
        @(negedge clk); idle();
        n_checks++; if (dirty !== 8'h00) begin n_fail++; $display("FAIL clr_dirty: got %h exp 00", dirty); end
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'h55AA55AA) begin n_fail++; $display("FAIL clr_write_data: got %h exp 55aa55aa", rd_data_a); end
    endtask

    task automatic test_out_of_range();
        wr_en6 = 1'b1; wr_addr6 = 3'd5; wr_data6 = 32'h12345678; wr_be6 = 4'hF;
        @(negedge clk); idle();
        rd_en_a6 = 1'b1; rd_addr_a6 = 3'd5;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a6 !== 32'h12345678) begin n_fail++; $display("FAIL oor_prime: got %h exp 12345678", rd_data_a6); end
        n_checks++; if (err6 !== 1'b0) begin n_fail++; $display("FAIL oor_prime_err: got %b exp 0", err6); end
        n_checks++; if (dirty6 !== 6'h20) begin n_fail++; $display("FAIL oor_prime_dirty: got %h exp 20", dirty6); end
        wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 32'hFFFFFFFF; wr_be6 = 4'hF;
        rd_en_a6 = 1'b1; rd_addr_a6 = 3'd6;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a6 !== 32'h0) begin n_fail++; $display("FAIL oor_rd_zero: got %h exp 0", rd_data_a6); end
        n_checks++; if (err6 !== 1'b1) begin n_fail++; $display("FAIL oor_err_set: got %b exp 1", err6); end
        n_checks++; if (dirty6 !== 6'h20) begin n_fail++; $display("FAIL oor_dirty: got %h exp 20", dirty6); end
        @(negedge clk);
        n_checks++; if (err6 !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b exp 0", err6); end
        rd_en_a6 = 1'b1; rd_addr_a6 = 3'd5; rd_en_b6 = 1'b1; rd_addr_b6 = 3'd0;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a6 !== 32'h12345678) begin n_fail++; $display("FAIL oor_storage5: got %h exp 12345678", rd_data_a6); end
        n_checks++; if (rd_data_b6 !== 32'h0) begin n_fail++; $display("FAIL oor_storage0: got %h exp 0", rd_data_b6); end
        // Write-only out-of-range access
        wr_en6 = 1'b1; wr_addr6 = 3'd6; wr_data6 = 32'hFFFFFFFF; wr_be6 = 4'hF;
        @(negedge clk); idle();
        n_checks++; if (err6 !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b exp 1", err6); end
        // Disabled read at an out-of-range index must not flag
        rd_en_a6 = 1'b0; rd_addr_a6 = 3'd7;
        @(negedge clk); idle();
        n_checks++; if (err6 !== 1'b0) begin n_fail++; $display("FAIL oor_disabled_err: got %b exp 0", err6); end
        rd_en_b6 = 1'b1; rd_addr_b6 = 3'd5;
        @(negedge clk); idle();
        rd_en_b6 = 1'b1; rd_addr_b6 = 3'd6;
        @(negedge clk); idle();
        n_checks++; if (rd_data_b6 !== 32'h0) begin n_fail++; $display("FAIL oor_rd_b_zero: got %h exp 0", rd_data_b6); end
        n_checks++; if (err6 !== 1'b1) begin n_fail++; $display("FAIL oor_rd_b_err: got %b exp 1", err6); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0BADCAFE; wr_be = 4'hF;
        rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd3;
        @(negedge clk); idle();
        n_checks++; if (rd_data_a !== 32'h55AA55AA) begin n_fail++; $display("FAIL prerst_a: got %h exp 55aa55aa", rd_data_a); end
        n_checks++; if (dirty !== 8'h04) begin n_fail++; $display("FAIL prerst_dirty: got %h exp 04", dirty); end
        // Accesses held during reset must be discarded
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en_a = 1'b1; rd_addr_a = 3'd2;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL async_rd_a: got %h exp 0", rd_data_a); end
        n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL async_rd_b: got %h exp 0", rd_data_b); end
        n_checks++; if (dirty !== 8'h00) begin n_fail++; $display("FAIL async_dirty: got %h exp 00", dirty); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_err: got %b exp 0", err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle();
        for (int r = 0; r < 8; r++) begin
            rd_en_a = 1'b1; rd_addr_a = 3'(r); rd_en_b = 1'b1; rd_addr_b = 3'(7 - r);
            @(negedge clk); idle();
            n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL postrst_a_%0d: got %h exp 0", r, rd_data_a); end
            n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL postrst_b_%0d: got %h exp 0", 7 - r, rd_data_b); end
        end
        n_checks++; if (dirty !== 8'h00) begin n_fail++; $display("FAIL postrst_dirty: got %h exp 00", dirty); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_first();
        test_dual_read();
        test_hold();
        test_clr_write();
        test_out_of_range();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
